// File: rtl/cache_core_ctrl_pkg.sv
// Shared cache types: address fields, word/line payloads, and controller states.
package cache_core_ctrl_pkg;

  localparam int unsigned TAG_W    = 8;
  localparam int unsigned INDEX_W  = 4;
  localparam int unsigned OFFSET_W = 2;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned LINE_W   = 128;
  localparam int unsigned BE_W     = 4;
  localparam int unsigned ADDR_W   = TAG_W + INDEX_W + OFFSET_W;

  typedef logic [TAG_W-1:0]    addr_tag;
  typedef logic [INDEX_W-1:0]  addr_index;
  typedef logic [OFFSET_W-1:0] addr_offset;
  typedef logic [WORD_W-1:0]   word;
  typedef logic [LINE_W-1:0]   line;

  // Word address as seen on the core bus.
  typedef struct packed {
    addr_tag    tag;
    addr_index  index;
    addr_offset offset;
  } core_addr;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    FILL   = 2'd2,
    RESP   = 2'd3
  } ctrl_state;

  // Select one word out of a line.
  function automatic word line_word(line l, addr_offset off);
    return l[32'(off)*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/cache_core_ctrl_if.sv
// Avalon-style core request bus.
//   master: the core (drives address/read/write/lock/writedata/byteenable)
//   slave : the cache controller (drives waitrequest/readdata)
interface cache_core_ctrl_if;
  import cache_core_ctrl_pkg::*;

  core_addr        address;
  logic            read;
  logic            write;
  logic            lock;
  word             writedata;
  logic [BE_W-1:0] byteenable;
  logic            waitrequest;
  word             readdata;

  modport master (
    output address, read, write, lock, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, write, lock, writedata, byteenable,
    output waitrequest, readdata
  );

endinterface

// File: rtl/cache_core_ctrl_line_merge.sv
// Byte-lane merge of one word into a cache line.
//   base       : original line
//   data       : word to merge
//   offset     : word position within the line
//   byteenable : lanes of data that replace the original bytes
//   merged     : resulting line
module cache_line_merge
  import cache_core_ctrl_pkg::*;
(
  input  line             base,
  input  word             data,
  input  addr_offset      offset,
  input  logic [BE_W-1:0] byteenable,
  output line             merged
);

  localparam int unsigned BYTE_W = 8;

  always_comb begin
    merged = base;
    for (int unsigned b = 0; b < BE_W; b++) begin
      if (byteenable[b]) begin
        merged[32'(offset)*WORD_W + b*BYTE_W +: BYTE_W] = data[b*BYTE_W +: BYTE_W];
      end
    end
  end

endmodule

// File: rtl/cache_core_ctrl.sv
// Core-side request sequencer for a private cache in front of the exclusive
// monitor: tag lookup, fill request on miss, write merge, ldrex/strex strobes.
//   clk, rst          : clock, synchronous active-high reset
//   core              : Avalon core bus (slave side)
//   cache_index       : array index (incoming index in IDLE, latched after)
//   cache_tag_rd/cache_valid_rd/data_rd : array read data, 1-cycle latency
//   cache_write/cache_data_wr : array write strobe and line
//   fill_req/fill_done: miss handshake with the fill unit
//   mon_*             : latched request presented to the monitor
//   monitor_acquire/release/fail : exclusive strobes
//   monitor_update/monitor_commit: monitor-merged line and store grant
module cache_core_ctrl
  import cache_core_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  cache_core_ctrl_if.slave core,
  output addr_index  cache_index,
  input  addr_tag    cache_tag_rd,
  input  logic       cache_valid_rd,
  input  line        data_rd,
  output logic       cache_write,
  output line        cache_data_wr,
  output logic       fill_req,
  input  logic       fill_done,
  output addr_tag    mon_tag,
  output addr_index  mon_index,
  output addr_offset mon_offset,
  output logic       mon_lock,
  output word        mon_writedata,
  output logic       monitor_acquire,
  output logic       monitor_release,
  output logic       monitor_fail,
  input  line        monitor_update,
  input  logic       monitor_commit
);

  ctrl_state       state, state_nx;
  core_addr        req_addr;
  logic            req_write;
  logic            req_lock;
  word             req_wdata;
  logic [BE_W-1:0] req_be;
  word             readdata_q;
  logic            ex_fail;

  logic accept;
  logic hit;
  logic load_word;
  logic fail_set;
  logic wait_c;
  line  merged_line;

  assign accept = (state == IDLE) && (core.read || core.write);
  assign hit    = cache_valid_rd && (cache_tag_rd == req_addr.tag);

  // Index goes out in IDLE so the synchronous array has data ready in LOOKUP.
  assign cache_index = (state == IDLE) ? core.address.index : req_addr.index;

  assign core.waitrequest = wait_c;
  assign core.readdata    = readdata_q;
  assign mon_tag          = req_addr.tag;
  assign mon_index        = req_addr.index;
  assign mon_offset       = req_addr.offset;
  assign mon_lock         = req_lock;
  assign mon_writedata    = req_wdata;

  cache_line_merge u_merge (
    .base       (data_rd),
    .data       (req_wdata),
    .offset     (req_addr.offset),
    .byteenable (req_be),
    .merged     (merged_line)
  );

  // State and request latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_addr   <= '0;
      req_write  <= 1'b0;
      req_lock   <= 1'b0;
      req_wdata  <= '0;
      req_be     <= '0;
      readdata_q <= '0;
      ex_fail    <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        req_addr  <= core.address;
        req_write <= core.write;  // write wins over a simultaneous read
        req_lock  <= core.lock;
        req_wdata <= core.writedata;
        req_be    <= core.byteenable;
      end
      if (load_word) begin
        readdata_q <= line_word(data_rd, req_addr.offset);
      end
      if (state == LOOKUP) begin
        ex_fail <= fail_set;
      end
    end
  end

  // Next state and strobes; everything idles while rst is high.
  always_comb begin
    state_nx        = state;
    wait_c          = 1'b1;
    fill_req        = 1'b0;
    cache_write     = 1'b0;
    cache_data_wr   = '0;
    monitor_acquire = 1'b0;
    monitor_release = 1'b0;
    monitor_fail    = 1'b0;
    load_word       = 1'b0;
    fail_set        = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (accept) state_nx = LOOKUP;
        end
        LOOKUP: begin
          if (!hit) begin
            state_nx = FILL;
          end else begin
            state_nx = RESP;
            if (!req_write) begin
              load_word       = 1'b1;
              monitor_acquire = req_lock;
            end else if (!req_lock) begin
              cache_write   = 1'b1;
              cache_data_wr = merged_line;
            end else if ((req_be == '1) && monitor_commit) begin
              cache_write     = 1'b1;
              cache_data_wr   = monitor_update;
              monitor_release = 1'b1;
            end else begin
              fail_set = 1'b1;
            end
          end
        end
        FILL: begin
          fill_req = 1'b1;
          if (fill_done) state_nx = LOOKUP;  // re-read the freshly installed line
        end
        RESP: begin
          wait_c       = 1'b0;
          monitor_fail = ex_fail;
          state_nx     = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_core_ctrl.sv
module tb_cache_core_ctrl;
  import cache_core_ctrl_pkg::*;

  typedef logic [127:0] line_t;

  typedef struct {
    logic        rd, wr, lk;
    logic [7:0]  tag;
    logic [3:0]  idx;
    logic [1:0]  off;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        commit;
    line_t       upd;
    int          fill_lat;
    int          e_lat, e_fills;
    logic        chk_rd;
    logic [31:0] e_rd;
    int          e_wr;
    line_t       e_line;
    int          e_acq, e_rel, e_fail;
  } vec_t;

  typedef struct {
    int          done, lat, fills, writes, acq, rel, fails, excl_bad, fail_outside;
    line_t       wline;
    logic [31:0] rdata;
    logic [13:0] mon_addr;
    logic [31:0] mon_wdata;
    logic        mon_lock;
  } obs_t;

  localparam line_t PRE_LINE = {32'hCAFEF00D, 32'hDEADBEEF, 32'h11223344, 32'h01020304};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_core_ctrl_if core_bus();
  addr_index  cache_index;
  addr_tag    cache_tag_rd;
  logic       cache_valid_rd;
  line        data_rd;
  logic       cache_write;
  line        cache_data_wr;
  logic       fill_req;
  logic       fill_done;
  addr_tag    mon_tag;
  addr_index  mon_index;
  addr_offset mon_offset;
  logic       mon_lock;
  word        mon_writedata;
  logic       monitor_acquire, monitor_release, monitor_fail;
  line        monitor_update;
  logic       monitor_commit;

  cache_core_ctrl dut (
    .clk(clk), .rst(rst), .core(core_bus),
    .cache_index(cache_index), .cache_tag_rd(cache_tag_rd),
    .cache_valid_rd(cache_valid_rd), .data_rd(data_rd),
    .cache_write(cache_write), .cache_data_wr(cache_data_wr),
    .fill_req(fill_req), .fill_done(fill_done),
    .mon_tag(mon_tag), .mon_index(mon_index), .mon_offset(mon_offset),
    .mon_lock(mon_lock), .mon_writedata(mon_writedata),
    .monitor_acquire(monitor_acquire), .monitor_release(monitor_release),
    .monitor_fail(monitor_fail), .monitor_update(monitor_update),
    .monitor_commit(monitor_commit)
  );

  // Deterministic backing-store contents used by the fill unit.
  function automatic logic [31:0] backing_word(logic [7:0] tag, logic [3:0] idx, logic [1:0] k);
    return {tag, idx, k, 18'h2A5A5};
  endfunction

  function automatic line_t backing_line(logic [7:0] tag, logic [3:0] idx);
    return {backing_word(tag, idx, 2'd3), backing_word(tag, idx, 2'd2),
            backing_word(tag, idx, 2'd1), backing_word(tag, idx, 2'd0)};
  endfunction

  // Tag/data array with 1-cycle read latency plus a fill unit.
  logic [7:0] arr_tag   [16];
  logic       arr_valid [16];
  line_t      arr_line  [16];
  logic       preload;
  int         fill_lat;
  int         fcnt;

  always @(posedge clk) begin
    cache_tag_rd   <= arr_tag[cache_index];
    cache_valid_rd <= arr_valid[cache_index];
    data_rd        <= arr_line[cache_index];
    if (preload) begin
      for (int i = 0; i < 16; i++) begin
        arr_tag[i] <= 8'h00; arr_valid[i] <= 1'b0; arr_line[i] <= '0;
      end
      arr_tag[3] <= 8'h12; arr_valid[3] <= 1'b1; arr_line[3] <= PRE_LINE;
    end else if (cache_write) begin
      arr_line[cache_index] <= cache_data_wr;
    end
    if (rst) begin
      fill_done <= 1'b0; fcnt <= 0;
    end else if (fill_done) begin
      fill_done <= 1'b0;
    end else if (fill_req) begin
      if (fcnt >= fill_lat - 1) begin
        arr_tag[mon_index]   <= mon_tag;
        arr_valid[mon_index] <= 1'b1;
        arr_line[mon_index]  <= backing_line(mon_tag, mon_index);
        fill_done <= 1'b1;
        fcnt <= 0;
      end else begin
        fcnt <= fcnt + 1;
      end
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_i(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_l(input string nm, input line_t act, input line_t exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference cache image, tracked per transaction.
  logic [7:0] ref_tag   [16];
  logic       ref_valid [16];
  line_t      ref_line  [16];

  function automatic line_t ref_merge(line_t l, logic [31:0] w, logic [1:0] off, logic [3:0] be);
    logic [31:0] old, mask;
    line_t r;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    old  = l[32*off +: 32];
    r    = l;
    r[32*off +: 32] = (old & ~mask) | (w & mask);
    return r;
  endfunction

  function automatic vec_t blank();
    vec_t v;
    v.rd = 0; v.wr = 0; v.lk = 0; v.tag = 0; v.idx = 0; v.off = 0; v.wdata = 0;
    v.be = 4'hF; v.commit = 0; v.upd = '0; v.fill_lat = 1; v.e_lat = 3; v.e_fills = 0;
    v.chk_rd = 0; v.e_rd = 0; v.e_wr = 0; v.e_line = '0; v.e_acq = 0; v.e_rel = 0; v.e_fail = 0;
    return v;
  endfunction

  // Expected behaviour of one transaction; updates the reference image.
  task automatic ref_step(inout vec_t v);
    line_t l, m;
    v.e_lat = 3; v.e_fills = 0; v.chk_rd = 0; v.e_rd = 0;
    v.e_wr = 0; v.e_line = '0; v.e_acq = 0; v.e_rel = 0; v.e_fail = 0;
    if (!(ref_valid[v.idx] && ref_tag[v.idx] == v.tag)) begin
      ref_tag[v.idx] = v.tag; ref_valid[v.idx] = 1'b1;
      ref_line[v.idx] = backing_line(v.tag, v.idx);
      v.e_fills = v.fill_lat + 1;  // fill_done arrives fill_lat cycles after fill_req
      v.e_lat = 3 + v.e_fills + 1;
    end
    l = ref_line[v.idx];
    if (!v.wr) begin
      v.chk_rd = 1; v.e_rd = l[32*v.off +: 32]; v.e_acq = int'(v.lk);
    end else begin
      m = ref_merge(l, v.wdata, v.off, v.be);
      if (!v.lk) begin
        v.e_wr = 1; v.e_line = m; ref_line[v.idx] = m;
      end else begin
        v.upd = m;
        if (v.be == 4'hF && v.commit) begin
          v.e_wr = 1; v.e_line = m; v.e_rel = 1; ref_line[v.idx] = m;
        end else begin
          v.e_fail = 1;
        end
      end
    end
  endtask

  task automatic do_txn(input vec_t v, output obs_t o);
    o.done = 0; o.lat = 0; o.fills = 0; o.writes = 0; o.acq = 0; o.rel = 0; o.fails = 0;
    o.excl_bad = 0; o.fail_outside = 0; o.wline = '0; o.rdata = 0;
    o.mon_addr = 0; o.mon_wdata = 0; o.mon_lock = 0;
    @(negedge clk);
    core_bus.address = {v.tag, v.idx, v.off};
    core_bus.read = v.rd; core_bus.write = v.wr; core_bus.lock = v.lk;
    core_bus.writedata = v.wdata; core_bus.byteenable = v.be;
    monitor_commit = v.commit; monitor_update = v.upd; fill_lat = v.fill_lat;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (fill_req) o.fills++;
      if (cache_write) begin o.writes++; o.wline = cache_data_wr; end
      if (monitor_acquire) o.acq++;
      if (monitor_release) o.rel++;
      if (monitor_fail) o.fails++;
      if (int'(monitor_acquire) + int'(monitor_release) + int'(monitor_fail) > 1) o.excl_bad = 1;
      if (monitor_fail && core_bus.waitrequest) o.fail_outside = 1;
      if (!core_bus.waitrequest) begin
        o.done = 1; o.lat = c + 1; o.rdata = core_bus.readdata;
        o.mon_addr = {mon_tag, mon_index, mon_offset};
        o.mon_wdata = mon_writedata; o.mon_lock = mon_lock;
        break;
      end
    end
    core_bus.read = 0; core_bus.write = 0; core_bus.lock = 0; monitor_commit = 0;
  endtask

  task automatic compare(input int n, input vec_t v, input obs_t o);
    string p;
    p = $sformatf("t%0d_", n);
    check_i({p, "done"}, o.done, 1);
    check_i({p, "latency"}, o.lat, v.e_lat);
    check_i({p, "fill_cycles"}, o.fills, v.e_fills);
    if (v.chk_rd) check_i({p, "readdata"}, int'(o.rdata), int'(v.e_rd));
    check_i({p, "cache_writes"}, o.writes, v.e_wr);
    if (v.e_wr != 0) check_l({p, "cache_data_wr"}, o.wline, v.e_line);
    check_i({p, "acquire"}, o.acq, v.e_acq);
    check_i({p, "release"}, o.rel, v.e_rel);
    check_i({p, "fail"}, o.fails, v.e_fail);
    check_i({p, "strobe_overlap"}, o.excl_bad, 0);
    check_i({p, "fail_outside_resp"}, o.fail_outside, 0);
    check_i({p, "mon_addr"}, int'(o.mon_addr), int'({v.tag, v.idx, v.off}));
    check_i({p, "mon_wdata"}, int'(o.mon_wdata), int'(v.wdata));
    check_i({p, "mon_lock"}, int'(o.mon_lock), int'(v.lk));
  endtask

  task automatic check_idle(input string p);
    check_i({p, "_waitrequest"}, int'(core_bus.waitrequest), 1);
    check_i({p, "_fill_req"}, int'(fill_req), 0);
    check_i({p, "_cache_write"}, int'(cache_write), 0);
    check_i({p, "_strobes"}, int'({monitor_acquire, monitor_release, monitor_fail}), 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[$];
    vec_t v, c;
    obs_t o;
    logic [7:0] pool [3];
    int op;
    pool[0] = 8'h12; pool[1] = 8'h34; pool[2] = 8'h56;

    core_bus.address = '0; core_bus.read = 0; core_bus.write = 0; core_bus.lock = 0;
    core_bus.writedata = 0; core_bus.byteenable = 0;
    monitor_commit = 0; monitor_update = '0; fill_lat = 1;
    for (int i = 0; i < 16; i++) begin ref_tag[i] = 0; ref_valid[i] = 0; ref_line[i] = '0; end
    ref_tag[3] = 8'h12; ref_valid[3] = 1; ref_line[3] = PRE_LINE;

    rst = 1; preload = 1;
    repeat (3) @(negedge clk);
    rst = 0; preload = 0;
    #1 check_idle("reset");

    // Directed table.
    v = blank(); v.rd = 1; v.tag = 8'h12; v.idx = 3; v.off = 2;
    v.chk_rd = 1; v.e_rd = 32'hDEADBEEF; tv.push_back(v);
    v = blank(); v.rd = 1; v.tag = 8'h34; v.idx = 5; v.off = 1; v.fill_lat = 3;
    v.e_fills = 4; v.e_lat = 8; v.chk_rd = 1; v.e_rd = backing_word(8'h34, 4'd5, 2'd1); tv.push_back(v);
    v = blank(); v.wr = 1; v.tag = 8'h12; v.idx = 3; v.off = 1; v.wdata = 32'hAAAA5555; v.be = 4'b0011;
    v.e_wr = 1; v.e_line = {32'hCAFEF00D, 32'hDEADBEEF, 32'h11225555, 32'h01020304}; tv.push_back(v);
    v = blank(); v.rd = 1; v.lk = 1; v.tag = 8'h12; v.idx = 3; v.off = 2;
    v.chk_rd = 1; v.e_rd = 32'hDEADBEEF; v.e_acq = 1; tv.push_back(v);
    v = blank(); v.wr = 1; v.lk = 1; v.tag = 8'h12; v.idx = 3; v.off = 2; v.wdata = 32'h600DF00D;
    v.commit = 1; v.upd = {32'hCAFEF00D, 32'h600DF00D, 32'h11225555, 32'h01020304};
    v.e_wr = 1; v.e_line = v.upd; v.e_rel = 1; tv.push_back(v);
    v = blank(); v.wr = 1; v.lk = 1; v.tag = 8'h12; v.idx = 3; v.off = 0; v.wdata = 32'h12345678;
    v.commit = 0; v.upd = '1; v.e_fail = 1; tv.push_back(v);
    v = blank(); v.wr = 1; v.lk = 1; v.tag = 8'h12; v.idx = 3; v.off = 0; v.wdata = 32'h12345678;
    v.be = 4'b0011; v.commit = 1; v.upd = '1; v.e_fail = 1; tv.push_back(v);
    v = blank(); v.rd = 1; v.wr = 1; v.tag = 8'h12; v.idx = 3; v.off = 3; v.wdata = 32'hBBBB0000;
    v.be = 4'b1100; v.e_wr = 1;
    v.e_line = {32'hBBBBF00D, 32'h600DF00D, 32'h11225555, 32'h01020304}; tv.push_back(v);
    v = blank(); v.rd = 1; v.tag = 8'h12; v.idx = 3; v.off = 3;
    v.chk_rd = 1; v.e_rd = 32'hBBBBF00D; tv.push_back(v);
    v = blank(); v.rd = 1; v.lk = 1; v.tag = 8'h56; v.idx = 3; v.off = 0; v.fill_lat = 1;
    v.e_fills = 2; v.e_lat = 6; v.chk_rd = 1; v.e_rd = backing_word(8'h56, 4'd3, 2'd0);
    v.e_acq = 1; tv.push_back(v);

    foreach (tv[i]) begin
      c = tv[i];
      ref_step(c);  // keeps the reference image in step with the table
      do_txn(tv[i], o);
      compare(i, tv[i], o);
    end

    // Reset in the middle of a fill.
    @(negedge clk);
    core_bus.address = {8'h77, 4'd7, 2'd0}; core_bus.read = 1; fill_lat = 10;
    repeat (3) @(negedge clk);
    check_i("rst_pre_fill_req", int'(fill_req), 1);
    rst = 1; core_bus.read = 0;
    @(negedge clk);
    rst = 0;
    #1 check_idle("rst_mid_fill");
    @(negedge clk);
    check_idle("rst_mid_fill_after");

    v = blank(); v.rd = 1; v.tag = 8'h56; v.idx = 3; v.off = 0;
    ref_step(v); do_txn(v, o); compare(50, v, o);

    // Randomized traffic against the reference image.
    for (int n = 0; n < 80; n++) begin
      v = blank();
      op = int'($urandom_range(0, 4));
      v.tag = pool[$urandom_range(0, 2)];
      v.idx = 4'($urandom_range(0, 3));
      v.off = 2'($urandom_range(0, 3));
      v.wdata = $urandom;
      v.be = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(1, 15));
      v.commit = 1'($urandom_range(0, 1));
      v.fill_lat = int'($urandom_range(1, 4));
      case (op)
        0: v.rd = 1;
        1: v.wr = 1;
        2: begin v.rd = 1; v.lk = 1; end
        3: begin v.wr = 1; v.lk = 1; end
        default: begin v.rd = 1; v.wr = 1; end
      endcase
      ref_step(v);
      do_txn(v, o);
      compare(100 + n, v, o);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cache_core_ctrl.md
Name: cache_core_ctrl

Overview:
Core-side request sequencer for one core's private cache, directly upstream of the exclusive monitor. It accepts Avalon-style core reads and writes, including ldrex (read+lock) and strex (write+lock). It performs the tag lookup, requests line fills on a miss, and merges write data into the cache line. It drives the monitor's acquire/release/fail strobes and commits monitor_update to the data array when the monitor grants the store.

Parameters:
None. All widths come from the shared cache package: addr_tag, addr_index, addr_offset (2 bits, word within 4-word line), word (32), line (128).

Ports:
clk  in  1  clock
rst  in  1  reset. Synchronous, active-high.
core_address  in  $bits(tag)+$bits(index)+2  word address as {tag,index,offset}
core_read  in  1  read request
core_write  in  1  write request
core_lock  in  1  exclusive qualifier (ldrex/strex)
core_writedata  in  32  store data
core_byteenable  in  4  byte lanes
core_waitrequest  out  1  Avalon stall
core_readdata  out  32  load data, valid when waitrequest low on a read
cache_index  out  index  array read/write index
cache_tag_rd  in  tag  stored tag, 1-cycle read latency
cache_valid_rd  in  1  stored valid bit
data_rd  in  128  stored line, 1-cycle read latency
cache_write  out  1  write strobe for the data array and dirty bit
cache_data_wr  out  128  line to write
fill_req  out  1  miss request to the fill/writeback unit
fill_done  in  1  one-cycle pulse when the line has been installed
mon_tag / mon_index / mon_offset  out  package types  latched request address to the monitor
mon_lock  out  1  latched core_lock
mon_writedata  out  32  latched store data
monitor_acquire  out  1  ldrex strobe
monitor_release  out  1  successful strex strobe
monitor_fail  out  1  failed strex, held during the response cycle
monitor_update  in  128  line with the store merged, supplied by the monitor
monitor_commit  in  1  monitor grants the exclusive store

Behaviour:
- FSM states: IDLE, LOOKUP, FILL, RESP. Reset (any cycle, including mid-FILL) forces IDLE.
- Outputs in reset and in IDLE: waitrequest=1; fill_req, cache_write, acquire, release, fail all 0.
- IDLE
  - On core_read|core_write, latch address, data, byteenable, lock and op, then go to LOOKUP.
  - If read and write are both high, the write wins.
  - cache_index drives the latched index from LOOKUP onward.
- LOOKUP (array data valid this cycle). hit = cache_valid_rd && cache_tag_rd == latched tag.
  - Miss: go to FILL.
  - Hit, plain read: latch the selected word into readdata, go to RESP.
  - Hit, ldrex: monitor_acquire=1 for one cycle, latch the word, go to RESP.
  - Hit, plain write: cache_write=1; cache_data_wr = data_rd with the offset word byte-merged per byteenable; go to RESP.
  - Hit, strex with byteenable=4'hF and monitor_commit=1: cache_write=1, cache_data_wr=monitor_update, monitor_release=1, go to RESP with ex_fail=0.
  - Hit, strex otherwise (no commit, or partial byteenable): no write, ex_fail=1, go to RESP.
- FILL
  - fill_req held at 1.
  - On fill_done, drop fill_req and go back to LOOKUP. The array is re-read, so a refilled line is looked up normally.
- RESP
  - waitrequest=0 for exactly one cycle; monitor_fail=ex_fail.
  - core_response (driven by the monitor) is therefore 2'b10 on a failed strex.
  - Next state: IDLE.
- Latency: hit = 3 cycles from request to waitrequest low. Miss = 3 cycles + fill time + 1 relookup cycle.
- mon_* outputs are registered from the latch and stable from LOOKUP through RESP.
- Acquire, release and fail are mutually exclusive and never asserted outside the states above.

Decomposition:
- Package (cache/defs): addr_tag, addr_index, addr_offset, word, line; ctrl_state enum {IDLE, LOOKUP, FILL, RESP}.
- Sub-module cache_line_merge: combinational line+word+offset+byteenable merge, reusable by the fill unit.

Test Plan:
- Preload tag 0x12/index 3 valid, read offset 2 holding 0xDEADBEEF -> waitrequest low on cycle 3, readdata=0xDEADBEEF, no fill_req.
- Read to an invalid line -> fill_req high until fill_done; relookup hits; readdata correct; total = fill latency + 4.
- Plain write offset 1, byteenable 4'b0011, data 0xAAAA5555 over 0x11223344 -> cache_data_wr word1=0x11225555, other words unchanged.
- ldrex, then strex with monitor_commit=1 -> acquire pulse once, then release pulse, cache_write with monitor_update, core_response=00.
- strex with monitor_commit=0 -> no cache_write, monitor_fail=1 only in the RESP cycle, core_response=2'b10.
- rst asserted during FILL -> next cycle IDLE, fill_req=0, waitrequest=1; a new request after reset completes normally.
